// File: rtl/shift_stream_if.sv
// Bundles the pixel stream, preload, window handshake and shift-register control
// signals of shift_stream_ctrl.
interface shift_stream_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
);
  logic                   s_valid;
  logic                   s_ready;
  logic [WIDTH-1:0]       s_data;
  logic                   s_last;
  logic                   flush;
  logic                   pre_valid;
  logic                   pre_ready;
  logic [WIDTH*DEPTH-1:0] pre_data;
  logic                   sr_load;
  logic                   sr_shift;
  logic [WIDTH-1:0]       sr_serial_in;
  logic [WIDTH*DEPTH-1:0] sr_parallel_in;
  logic                   win_valid;
  logic                   win_ready;
  logic                   win_last;
  logic [CNT_W-1:0]       fill_count;

  modport master (
    output s_valid, s_data, s_last, flush, pre_valid, pre_data, win_ready,
    input  s_ready, pre_ready, sr_load, sr_shift, sr_serial_in, sr_parallel_in,
    input  win_valid, win_last, fill_count
  );

  modport slave (
    input  s_valid, s_data, s_last, flush, pre_valid, pre_data, win_ready,
    output s_ready, pre_ready, sr_load, sr_shift, sr_serial_in, sr_parallel_in,
    output win_valid, win_last, fill_count
  );
endinterface

// File: rtl/shift_stream_ctrl.sv
// Feeder for a WIDTH x DEPTH pixel shift register: accepts a pixel stream and preloads,
// tracks fill level and presents a sliding-window handshake to the tap consumer.
module shift_stream_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           reset,
  shift_stream_if.slave bus
);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [CNT_W-1:0] fill_q, fill_d, fill_inc;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             free, accept, pre_accept, reached;

  // The consumer samples the taps on the same edge the register updates.
  assign free       = !win_valid_q || bus.win_ready;
  assign pre_accept = bus.pre_valid && bus.pre_ready;
  assign accept     = bus.s_valid && bus.s_ready;
  assign fill_inc   = (fill_q == FullCnt) ? FullCnt : fill_q + 1'b1;
  assign reached    = (fill_inc == FullCnt);

  assign bus.pre_ready      = !reset && !bus.flush && free;
  assign bus.s_ready        = !reset && !bus.flush && !bus.pre_valid && free;
  assign bus.sr_load        = !reset && (bus.flush || pre_accept);
  assign bus.sr_shift       = accept;
  assign bus.sr_serial_in   = accept ? bus.s_data : '0;
  assign bus.sr_parallel_in = pre_accept ? bus.pre_data : '0;
  assign bus.win_valid      = win_valid_q;
  assign bus.win_last       = win_last_q;
  assign bus.fill_count     = fill_q;

  always_comb begin
    fill_d      = fill_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    if (win_valid_q && bus.win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
    if (bus.flush) begin
      fill_d      = '0;
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end else if (pre_accept) begin
      fill_d      = FullCnt;
      win_valid_d = 1'b1;
      win_last_d  = 1'b0;
    end else if (accept) begin
      // A line end restarts filling so windows never span two lines.
      fill_d = bus.s_last ? '0 : fill_inc;
      if (reached) begin
        win_valid_d = 1'b1;
        win_last_d  = bus.s_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q      <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

endmodule

// File: tb/tb_shift_stream_ctrl.sv
// Directed and randomized bench for shift_stream_ctrl against a cycle-level reference
// model of the stream rules plus a model shift register driven by the DUT controls.
module tb_shift_stream_ctrl;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_stream_if #(.WIDTH(W), .DEPTH(D)) bus ();

  shift_stream_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pixels currently held per tap, fill level, pending window.
  logic [W-1:0]   m_pix [D];
  int             m_cnt;
  bit             m_wv;
  bit             m_wl;
  // Shift register as driven by the DUT's sr_* outputs.
  logic [W*D-1:0] reg_taps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit fl, input bit pv, input logic [W*D-1:0] pd,
                      input bit sv, input logic [W-1:0] sd, input bit sl, input bit wr);
    bit             free, e_pr, e_sr, acc, pacc;
    int             inc;
    logic [W*D-1:0] e_taps;
    #1;
    reset         = rst;
    bus.flush     = fl;
    bus.pre_valid = pv;
    bus.pre_data  = pd;
    bus.s_valid   = sv;
    bus.s_data    = sd;
    bus.s_last    = sl;
    bus.win_ready = wr;
    #1;
    free = !m_wv || wr;
    e_pr = !rst && !fl && free;
    e_sr = e_pr && !pv;
    acc  = sv && e_sr;
    pacc = pv && e_pr;

    check("fill_count", 32'(bus.fill_count), 32'(m_cnt));
    check("win_valid", 32'(bus.win_valid), 32'(m_wv));
    if (m_wv) check("win_last", 32'(bus.win_last), 32'(m_wl));
    check("s_ready", 32'(bus.s_ready), 32'(e_sr));
    check("pre_ready", 32'(bus.pre_ready), 32'(e_pr));
    check("sr_load", 32'(bus.sr_load), 32'(!rst && (fl || pacc)));
    check("sr_shift", 32'(bus.sr_shift), 32'(acc));
    check("sr_serial_in", 32'(bus.sr_serial_in), acc ? 32'(sd) : 32'd0);
    check("sr_parallel_in", 32'(bus.sr_parallel_in), pacc ? 32'(pd) : 32'd0);
    if (!rst && m_wv && wr) begin
      for (int i = 0; i < D; i++) e_taps[i*W +: W] = m_pix[i];
      check("win_taps", 32'(reg_taps), 32'(e_taps));
    end

    if (rst) begin
      for (int i = 0; i < D; i++) m_pix[i] = '0;
      m_cnt = 0;
      m_wv  = 0;
      m_wl  = 0;
    end else if (fl) begin
      for (int i = 0; i < D; i++) m_pix[i] = '0;
      m_cnt = 0;
      m_wv  = 0;
      m_wl  = 0;
    end else if (pacc) begin
      for (int i = 0; i < D; i++) m_pix[i] = pd[i*W +: W];
      m_cnt = D;
      m_wv  = 1;
      m_wl  = 0;
    end else if (acc) begin
      for (int i = 0; i < D - 1; i++) m_pix[i] = m_pix[i+1];
      m_pix[D-1] = sd;
      inc = (m_cnt + 1 > D) ? D : m_cnt + 1;
      if (inc == D) begin
        m_wv = 1;
        m_wl = sl;
      end else if (wr) begin
        m_wv = 0;
      end
      m_cnt = sl ? 0 : inc;
    end else if (m_wv && wr) begin
      m_wv = 0;
    end

    if (rst) reg_taps = '0;
    else if (bus.sr_load) reg_taps = bus.sr_parallel_in;
    else if (bus.sr_shift) reg_taps = {bus.sr_serial_in, reg_taps[W*D-1:W]};
    @(posedge clk);
  endtask

  task automatic push(input logic [W-1:0] sd, input bit sl, input bit wr);
    step(0, 0, 0, '0, 1, sd, sl, wr);
  endtask

  task automatic idle(input bit wr);
    step(0, 0, 0, '0, 0, '0, 0, wr);
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.pre_valid = 1'b0;
    bus.pre_data  = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_last    = 1'b0;
    bus.win_ready = 1'b0;
    for (int i = 0; i < D; i++) m_pix[i] = '0;
    m_cnt    = 0;
    m_wv     = 0;
    m_wl     = 0;
    reg_taps = '0;
    @(posedge clk);

    step(1, 0, 0, '0, 1, 8'h11, 0, 1);
    #2;
    check("rst_win_last", 32'(bus.win_last), 32'd0);

    // Fill and slide.
    for (int k = 1; k <= 5; k++) push(8'(k), 0, 1);
    // Backpressure with a window pending.
    push(8'd6, 0, 0);
    for (int k = 0; k < 10; k++) push(8'd7, 0, 0);
    push(8'd7, 0, 1);
    idle(1);
    idle(1);
    // Line end, then a short line.
    step(1, 0, 0, '0, 0, '0, 0, 1);
    for (int k = 1; k <= 6; k++) push(8'(k), k == 6, 1);
    idle(1);
    push(8'd1, 0, 1);
    push(8'd2, 1, 1);
    idle(1);
    // Preload against a valid stream.
    step(0, 0, 1, 32'h04030201, 1, 8'd9, 0, 1);
    push(8'd9, 0, 1);
    idle(1);
    // Flush with a pending window.
    push(8'd10, 0, 0);
    step(0, 1, 0, '0, 1, 8'd11, 0, 0);
    idle(1);
    // Reset mid-line.
    for (int k = 1; k <= 3; k++) push(8'(k), 0, 1);
    step(1, 0, 0, '0, 1, 8'd4, 0, 1);
    for (int k = 1; k <= 5; k++) push(8'(20 + k), 0, 1);
    idle(1);

    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 29) == 0, W*D'($urandom),
           $urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_stream_ctrl.md
Name: shift_stream_ctrl

Overview:
Upstream feeder for the parameterised WIDTH x DEPTH pixel shift register. It accepts a valid/ready pixel stream and drives the register's load/shift/serial_in/parallel_in controls. It tracks fill level and presents a sliding-window handshake (win_valid/win_ready) to the downstream consumer of the register's data_out taps. Line boundaries (s_last), flush and parallel preload are handled here, so the register itself stays a plain datapath.

Parameters:
WIDTH, 16, bits per pixel/tap
DEPTH, 16, number of taps in the downstream shift register (>= 2)
CNT_W, $clog2(DEPTH+1), width of fill_count

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
s_valid  input  1  input pixel valid
s_ready  output  1  input pixel accepted when s_valid && s_ready
s_data  input  WIDTH  input pixel
s_last  input  1  last pixel of line, qualified by accept
flush  input  1  one-cycle request: clear register and counters
pre_valid  input  1  parallel preload request
pre_ready  output  1  preload accepted when pre_valid && pre_ready
pre_data  input  WIDTH*DEPTH  preload image; tap i = bits [(i+1)*WIDTH-1 : i*WIDTH]
sr_load  output  1  to shift register load
sr_shift  output  1  to shift register shift
sr_serial_in  output  WIDTH  to shift register serial_in
sr_parallel_in  output  WIDTH*DEPTH  to shift register parallel_in
win_valid  output  1  register taps hold a complete window
win_ready  input  1  consumer takes window (samples taps at this edge)
win_last  output  1  window is last of its line, qualified by win_valid
fill_count  output  CNT_W  valid taps currently held, 0..DEPTH

Behaviour:
- Reset: win_valid=0, win_last=0, fill_count=0. s_ready, pre_ready, sr_load and sr_shift are 0 while reset is high. sr_serial_in and sr_parallel_in are 0.
- Priority each cycle: reset > flush > preload > stream accept.
- free = !win_valid || win_ready. This is combinational: a window is consumed on the same edge the register updates, and the consumer samples before the update.
- s_ready = !reset && !flush && !pre_valid && free. pre_ready = !reset && !flush && free.
- Stream accept (s_valid && s_ready):
  - sr_shift=1 and sr_serial_in=s_data in the same cycle (combinational pass-through), so the register shifts at that edge.
  - fill_count' = min(fill_count+1, DEPTH).
  - If fill_count' == DEPTH: win_valid'=1 and win_last'=s_last (sliding window; one window per accept once full).
  - Else: win_valid'=0 if win_ready, otherwise hold.
- s_last accept: fill_count' = 0 after the edge, overriding the saturate rule.
  - A window is produced only if the accept reached DEPTH. Windows never span lines.
  - A short line (fewer than DEPTH pixels) produces no window. The stale register contents are not cleared.
- Latency: accept at edge N, win_valid high from cycle N+1. win_valid and win_last hold stable until win_valid && win_ready.
- No accept while win_valid && !win_ready: register contents are frozen.
- Flush (flush=1):
  - sr_load=1 with sr_parallel_in=0.
  - fill_count'=0, win_valid'=0, win_last'=0.
  - A pending window is dropped even if win_ready=0.
  - No accept or preload in that cycle.
- Preload (pre_valid && pre_ready):
  - sr_load=1 with sr_parallel_in=pre_data.
  - fill_count'=DEPTH, win_valid'=1, win_last'=0.
  - Subsequent stream pixels slide from the preloaded taps.
- sr_load and sr_shift are never both 1. sr_parallel_in=0 when not preloading. sr_serial_in=s_data when shifting, else 0.
- Reset mid-line or with a pending window: everything returns to reset state next cycle, and no sr_load is issued. The register's own reset clears its contents.
- All state is registered. No combinational path from win_ready to win_valid.

Test Plan:
1. WIDTH=8, DEPTH=4, win_ready=1. Stream 1,2,3,4,5 (no last) -> win_valid first high the cycle after pixel 4 with taps {1,2,3,4}. Next window after 5 is {2,3,4,5}. fill_count=1,2,3,4,4.
2. Backpressure: win_ready=0 after first window -> s_ready=0, sr_shift=0, taps and win_valid frozen for 10 cycles. Raising win_ready gives the window one handshake, and the next pixel is accepted the same cycle.
3. Line end: stream 1..6 with s_last on 6 -> 3 windows; only the last has win_last=1. fill_count=0 after. Then a line of 2 pixels with s_last -> no window, fill_count back to 0.
4. Preload 0x04030201 with pre_valid while the stream is also valid -> sr_load=1, s_ready=0 that cycle, win_valid next cycle. fill_count=4. Next stream pixel 9 gives window {2,3,4,9}.
5. Flush while win_valid=1, win_ready=0, s_valid=1 -> sr_load=1, sr_parallel_in=0, no accept. win_valid=0 and fill_count=0 next cycle.
6. Reset asserted mid-line (fill_count=3) while s_valid=1 -> s_ready=0, sr_shift=0. Next cycle all outputs are at reset values, and a fresh line needs 4 pixels for its first window.
